// File: rtl/tqvp_gera_gray_seq_pkg.sv
// Shared constants for the queued Gray/binary conversion peripheral:
// register addresses, sequencer states, status bit positions and job modes.
package tqvp_gera_gray_seq_pkg;

    localparam int DEPTH = 4;

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_PUSH_B2G = 4'h1;
    localparam logic [3:0] ADDR_PUSH_G2B = 4'h2;
    localparam logic [3:0] ADDR_RESULT   = 4'h3;
    localparam logic [3:0] ADDR_COUNT    = 4'h4;

    localparam int ST_JOB_EMPTY = 0;
    localparam int ST_JOB_FULL  = 1;
    localparam int ST_RES_EMPTY = 2;
    localparam int ST_RES_FULL  = 3;
    localparam int ST_BUSY      = 4;
    localparam int ST_OVERFLOW  = 5;
    localparam int ST_UNDERFLOW = 6;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_STORE = 2'd2
    } state_t;

endpackage

// File: rtl/tqvp_gera_gray_fifo.sv
// Four-entry synchronous FIFO with occupancy count and synchronous flush.
// Push while full and pop while empty are ignored; the caller tracks errors.
module tqvp_gera_gray_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [2:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 3'(DEPTH));
    assign empty   = (count == 3'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (flush) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tqvp_gera_gray_seq.sv
// TinyQV peripheral: queued bit-serial Gray<->binary converter. Jobs are pushed
// into a FIFO, converted MSB-first one bit per cycle, and results queued for readout.
module tqvp_gera_gray_seq #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    import tqvp_gera_gray_seq_pkg::*;

    state_t     state;
    state_t     state_next;
    logic [7:0] shreg;
    logic [7:0] result;
    logic [2:0] bitcnt;
    logic       mode;
    logic       prev;
    logic       overflow;
    logic       underflow;

    logic       flush;
    logic       clr_flags;
    logic       push_req;
    logic       pop_req;
    logic [8:0] job_wdata;
    logic [8:0] job_rdata;
    logic [2:0] job_count;
    logic       job_full;
    logic       job_empty;
    logic       job_pop;
    logic [7:0] res_rdata;
    logic [2:0] res_count;
    logic       res_full;
    logic       res_empty;
    logic       res_push;
    logic       shift_in;
    logic       out_bit;
    logic       unused_ui;

    assign unused_ui = &{1'b0, ui_in};

    assign flush     = data_write && (address == ADDR_CTRL) && data_in[0];
    assign clr_flags = data_write && (address == ADDR_CTRL) && data_in[1];
    assign push_req  = data_write && ((address == ADDR_PUSH_B2G) || (address == ADDR_PUSH_G2B));
    assign pop_req   = data_write && (address == ADDR_RESULT);
    assign job_wdata = {(address == ADDR_PUSH_G2B) ? MODE_G2B : MODE_B2G, data_in};

    assign shift_in  = shreg[7];
    assign out_bit   = shift_in ^ prev;

    tqvp_gera_gray_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_job_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_req),
        .pop   (job_pop),
        .wdata (job_wdata),
        .rdata (job_rdata),
        .count (job_count),
        .full  (job_full),
        .empty (job_empty)
    );

    tqvp_gera_gray_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (res_push),
        .pop   (pop_req),
        .wdata (result),
        .rdata (res_rdata),
        .count (res_count),
        .full  (res_full),
        .empty (res_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        job_pop    = 1'b0;
        res_push   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!job_empty) begin
                    job_pop    = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bitcnt == 3'd0) state_next = ST_STORE;
            end
            ST_STORE: begin
                if (!res_full) begin
                    res_push   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    // B2G feeds back the raw input bit, G2B feeds back the decoded bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= 8'd0;
            result <= 8'd0;
            bitcnt <= 3'd0;
            mode   <= MODE_B2G;
            prev   <= 1'b0;
            uo_out <= 8'd0;
        end else if (flush) begin
            uo_out <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!job_empty) begin
                        shreg  <= job_rdata[7:0];
                        mode   <= job_rdata[8];
                        prev   <= 1'b0;
                        bitcnt <= 3'd7;
                    end
                end
                ST_SHIFT: begin
                    shreg  <= {shreg[6:0], 1'b0};
                    result <= {result[6:0], out_bit};
                    prev   <= (mode == MODE_G2B) ? out_bit : shift_in;
                    bitcnt <= bitcnt - 3'd1;
                end
                ST_STORE: begin
                    if (res_push) uo_out <= result;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_flags) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_req && job_full)  overflow  <= 1'b1;
            if (pop_req && res_empty)  underflow <= 1'b1;
        end
    end

    always_comb begin
        data_out = 8'd0;
        case (address)
            ADDR_CTRL: begin
                data_out[ST_JOB_EMPTY] = job_empty;
                data_out[ST_JOB_FULL]  = job_full;
                data_out[ST_RES_EMPTY] = res_empty;
                data_out[ST_RES_FULL]  = res_full;
                data_out[ST_BUSY]      = (state != ST_IDLE);
                data_out[ST_OVERFLOW]  = overflow;
                data_out[ST_UNDERFLOW] = underflow;
            end
            ADDR_RESULT: data_out = res_empty ? 8'd0 : res_rdata;
            ADDR_COUNT:  data_out = {1'b0, res_count, 1'b0, job_count};
            default:     data_out = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_tqvp_gera_gray_seq.sv
// Directed bench for tqvp_gera_gray_seq: conversions, ordering, overflow/stall,
// underflow, flush and asynchronous reset, each with hand-computed expectations.
module tb_tqvp_gera_gray_seq;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int tests_run;
    int tests_failed;

    tqvp_gera_gray_seq #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst_n = 1'b0;
        ui_in = 8'hA5;
        address = 4'h0;
        data_in = 8'h00;
        data_write = 1'b0;
        cycles(2);
        tests_run++;
        if (uo_out !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_uo_out: got %h expected 00", uo_out);
        end
        rst_n = 1'b1;
        cycles(1);
        rd(4'h0, d);
        tests_run++;
        if (d !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL reset_status: got %h expected 05", d);
        end
        rd(4'h4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %h expected 00", d);
        end
        @(negedge clk);
        wr(4'h7, 8'hFF);
        rd(4'h7, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL unmapped_read: got %h expected 00", d);
        end
        @(negedge clk);
    endtask

    task automatic test_single_b2g();
        logic [7:0] d;
        wr(4'h1, 8'h2D);
        cycles(9);
        rd(4'h4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL latency_before_store: count got %h expected 00", d);
        end
        @(negedge clk);
        rd(4'h3, d);
        tests_run++;
        if (d !== 8'h3B) begin
            tests_failed++;
            $display("[TB] FAIL b2g_2d_result: got %h expected 3b", d);
        end
        tests_run++;
        if (uo_out !== 8'h3B) begin
            tests_failed++;
            $display("[TB] FAIL b2g_2d_uo_out: got %h expected 3b", uo_out);
        end
        rd(4'h4, d);
        tests_run++;
        if (d !== 8'h10) begin
            tests_failed++;
            $display("[TB] FAIL b2g_2d_count: got %h expected 10", d);
        end
        rd(4'h0, d);
        tests_run++;
        if (d[4] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2g_2d_busy: got %b expected 0", d[4]);
        end
        @(negedge clk);
        wr(4'h3, 8'h00);
    endtask

    task automatic test_ordering();
        logic [7:0] d;
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h2D;
        exp_q[1] = 8'h80;
        exp_q[2] = 8'hFF;
        wr(4'h2, 8'h3B);
        wr(4'h1, 8'hFF);
        wr(4'h2, 8'h80);
        cycles(35);
        for (int i = 0; i < 3; i++) begin
            rd(4'h3, d);
            tests_run++;
            if (d !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL order_result_%0d: got %h expected %h", i, d, exp_q[i]);
            end
            @(negedge clk);
            wr(4'h3, 8'h00);
        end
        rd(4'h0, d);
        tests_run++;
        if (d !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL order_final_status: got %h expected 05", d);
        end
        @(negedge clk);
    endtask

    // The engine takes the first job one edge after it lands, so the sixth
    // consecutive push is the one that meets a full job queue.
    task automatic test_overflow_stall();
        logic [7:0] d;
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h03;
        exp_q[1] = 8'h02;
        exp_q[2] = 8'h06;
        exp_q[3] = 8'h07;
        for (int i = 1; i <= 6; i++) wr(4'h1, 8'(i));
        rd(4'h0, d);
        tests_run++;
        if (d !== 8'h36) begin
            tests_failed++;
            $display("[TB] FAIL overflow_status: got %h expected 36", d);
        end
        rd(4'h4, d);
        tests_run++;
        if (d !== 8'h04) begin
            tests_failed++;
            $display("[TB] FAIL overflow_count: got %h expected 04", d);
        end
        @(negedge clk);
        cycles(60);
        rd(4'h0, d);
        tests_run++;
        if (d !== 8'h39) begin
            tests_failed++;
            $display("[TB] FAIL stall_status: got %h expected 39", d);
        end
        rd(4'h4, d);
        tests_run++;
        if (d !== 8'h40) begin
            tests_failed++;
            $display("[TB] FAIL stall_count: got %h expected 40", d);
        end
        tests_run++;
        if (uo_out !== 8'h06) begin
            tests_failed++;
            $display("[TB] FAIL stall_uo_out: got %h expected 06", uo_out);
        end
        rd(4'h3, d);
        tests_run++;
        if (d !== 8'h01) begin
            tests_failed++;
            $display("[TB] FAIL stall_head: got %h expected 01", d);
        end
        @(negedge clk);
        wr(4'h3, 8'h00);
        rd(4'h4, d);
        tests_run++;
        if (d !== 8'h30) begin
            tests_failed++;
            $display("[TB] FAIL after_pop_count: got %h expected 30", d);
        end
        @(negedge clk);
        rd(4'h4, d);
        tests_run++;
        if (d !== 8'h40) begin
            tests_failed++;
            $display("[TB] FAIL stall_release_count: got %h expected 40", d);
        end
        rd(4'h0, d);
        tests_run++;
        if (d !== 8'h29) begin
            tests_failed++;
            $display("[TB] FAIL stall_release_status: got %h expected 29", d);
        end
        tests_run++;
        if (uo_out !== 8'h07) begin
            tests_failed++;
            $display("[TB] FAIL stall_release_uo_out: got %h expected 07", uo_out);
        end
        for (int i = 0; i < 4; i++) begin
            rd(4'h3, d);
            tests_run++;
            if (d !== exp_q[i]) begin
                tests_failed++;
                $display("[TB] FAIL stall_result_%0d: got %h expected %h", i, d, exp_q[i]);
            end
            @(negedge clk);
            wr(4'h3, 8'h00);
        end
        wr(4'h0, 8'h02);
        rd(4'h0, d);
        tests_run++;
        if (d !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL overflow_clear: got %h expected 05", d);
        end
        @(negedge clk);
    endtask

    task automatic test_underflow();
        logic [7:0] d;
        wr(4'h3, 8'h00);
        rd(4'h0, d);
        tests_run++;
        if (d !== 8'h45) begin
            tests_failed++;
            $display("[TB] FAIL underflow_status: got %h expected 45", d);
        end
        @(negedge clk);
        wr(4'h0, 8'h02);
        rd(4'h0, d);
        tests_run++;
        if (d !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL underflow_clear: got %h expected 05", d);
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [7:0] d;
        wr(4'h1, 8'h55);
        cycles(3);
        rd(4'h0, d);
        tests_run++;
        if (d[4] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_busy_before: got %b expected 1", d[4]);
        end
        @(negedge clk);
        wr(4'h0, 8'h01);
        rd(4'h0, d);
        tests_run++;
        if (d !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL flush_status: got %h expected 05", d);
        end
        rd(4'h4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL flush_count: got %h expected 00", d);
        end
        tests_run++;
        if (uo_out !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL flush_uo_out: got %h expected 00", uo_out);
        end
        cycles(15);
        rd(4'h4, d);
        tests_run++;
        if (d !== 8'h00 || uo_out !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL flush_no_result: count %h uo_out %h expected 00 00", d, uo_out);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        wr(4'h1, 8'h2D);
        cycles(10);
        tests_run++;
        if (uo_out !== 8'h3B) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_uo_out: got %h expected 3b", uo_out);
        end
        wr(4'h2, 8'h3B);
        cycles(4);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (uo_out !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_uo_out: got %h expected 00", uo_out);
        end
        rd(4'h4, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_count: got %h expected 00", d);
        end
        rd(4'h3, d);
        tests_run++;
        if (d !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_result: got %h expected 00", d);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(4'h0, d);
        tests_run++;
        if (d !== 8'h05) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_status: got %h expected 05", d);
        end
        @(negedge clk);
        wr(4'h2, 8'h3B);
        cycles(10);
        rd(4'h3, d);
        tests_run++;
        if (d !== 8'h2D) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_g2b: got %h expected 2d", d);
        end
        @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_single_b2g();
        test_ordering();
        test_overflow_stall();
        test_underflow();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
